// File: rtl/rv_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    // One IF/ID slot: what decode sees, and what the skid buffer holds.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
        logic            misalign;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0, misalign: 1'b0};

    // The ROM is word addressed; drop the byte offset.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction ROM port plus the IF/ID hand-off to decode.
// Latency: n/a (wires only).
// Backpressure: decode drives stall/redirect; the fetch stage obeys them.
interface if_fetch_if;
    import rv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] pc_id;
    logic [XLEN-1:0] instr_id;
    logic            valid_id;
    logic            misalign_id;

    modport master (
        output imem_req, imem_addr, pc_id, instr_id, valid_id, misalign_id,
        input  imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, pc_id, instr_id, valid_id, misalign_id,
        output imem_rdata, stall, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry holding slot for a ROM response that lands while IF/ID is stalled.
// Latency: push visible on dat/vld the cycle after; pop/clear take effect next cycle.
// Backpressure: none internally; the fetch request gate guarantees it never overflows.
module fetch_skid
    import rv_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  push,
    input  logic  pop,
    input  logic  clear,
    input  ifid_t push_dat,
    output logic  vld,
    output ifid_t dat
);

    logic  vld_q, vld_d;
    ifid_t dat_q, dat_d;

    // Clear wins (redirect flush); a push in the same cycle as a pop refills the slot.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (clear) begin
            vld_d = 1'b0;
        end else if (push) begin
            vld_d = 1'b1;
            dat_d = push_dat;
        end else if (pop) begin
            vld_d = 1'b0;
        end
    end

    // Slot storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
            dat_q <= IFID_BUBBLE;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld = vld_q;
    assign dat = dat_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: drives a 1-cycle ROM and fills the IF/ID register for decode.
// Latency: request -> IF/ID two edges later; redirect costs one bubble; 1 instr/cycle steady.
// Backpressure: stall holds IF/ID, the in-flight response parks in a 1-entry skid.
module if_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset_n,
    if_fetch_if.master bus
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_mis_q, inflight_mis_d;
    ifid_t           ifid_q, ifid_d;

    logic            req;
    logic [XLEN-1:0] addr;
    ifid_t           resp;
    logic            skid_vld;
    ifid_t           skid_dat;
    logic            skid_push, skid_pop, skid_clear;

    // Request side: redirect always fetches; otherwise hold off while stalled or while
    // the skid is full with another response on the way (it would have nowhere to go).
    always_comb begin
        addr = bus.redirect ? word_align(bus.redirect_pc) : fetch_pc_q;
        req  = reset_n & (bus.redirect | (~bus.stall & ~(skid_vld & inflight_q)));

        fetch_pc_d     = fetch_pc_q;
        inflight_d     = 1'b0;
        inflight_pc_d  = inflight_pc_q;
        inflight_mis_d = inflight_mis_q;
        if (req) begin
            fetch_pc_d     = addr + 32'd4;
            inflight_d     = 1'b1;
            // Keep the unaligned redirect PC so decode sees the address it jumped to.
            inflight_pc_d  = bus.redirect ? bus.redirect_pc : fetch_pc_q;
            inflight_mis_d = bus.redirect & (bus.redirect_pc[1:0] != 2'b00);
        end
    end

    // IF/ID update: redirect flushes, stall holds (response to skid), else drain skid first.
    always_comb begin
        resp       = '{pc: inflight_pc_q, instr: bus.imem_rdata, valid: 1'b1,
                       misalign: inflight_mis_q};
        ifid_d     = ifid_q;
        skid_push  = 1'b0;
        skid_pop   = 1'b0;
        skid_clear = 1'b0;
        if (bus.redirect) begin
            ifid_d     = IFID_BUBBLE;
            skid_clear = 1'b1;
        end else if (bus.stall) begin
            skid_push = inflight_q;
        end else if (skid_vld) begin
            ifid_d    = skid_dat;
            skid_pop  = 1'b1;
            skid_push = inflight_q;
        end else if (inflight_q) begin
            ifid_d = resp;
        end else begin
            ifid_d = IFID_BUBBLE;
        end
    end

    // Fetch state and IF/ID register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q     <= RESET_PC;
            inflight_q     <= 1'b0;
            inflight_pc_q  <= '0;
            inflight_mis_q <= 1'b0;
            ifid_q         <= IFID_BUBBLE;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            inflight_q     <= inflight_d;
            inflight_pc_q  <= inflight_pc_d;
            inflight_mis_q <= inflight_mis_d;
            ifid_q         <= ifid_d;
        end
    end

    fetch_skid u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (skid_push),
        .pop      (skid_pop),
        .clear    (skid_clear),
        .push_dat (resp),
        .vld      (skid_vld),
        .dat      (skid_dat)
    );

    assign bus.imem_req    = req;
    assign bus.imem_addr   = addr;
    assign bus.pc_id       = ifid_q.pc;
    assign bus.instr_id    = ifid_q.instr;
    assign bus.valid_id    = ifid_q.valid;
    assign bus.misalign_id = ifid_q.misalign;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cycle table with per-cycle expectations plus an in-order delivery scoreboard.
// Latency: n/a.
// Backpressure: stall/redirect patterns come from the table and hand-written sequences.
module tb_if_fetch;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    if_fetch_if ifc ();
    if_fetch_if ifc2 ();

    if_fetch u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc2)
    );

    // ROM model: word i holds value i, returned one cycle after the request.
    always @(posedge clk) begin
        if (ifc.imem_req)  ifc.imem_rdata  <= ifc.imem_addr >> 2;
        if (ifc2.imem_req) ifc2.imem_rdata <= ifc2.imem_addr >> 2;
    end

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    logic sb_en = 1'b0;
    logic prev_hold = 1'b0;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic v, input logic [31:0] pc, input logic [31:0] ins,
                                input logic m, input logic rq, input logic [31:0] ad);
        vec_t r;
        r = '{stall: st, redirect: rd, rpc: rpc, e_vld: v, e_pc: pc, e_instr: ins,
              e_mis: m, e_req: rq, e_addr: ad};
        return r;
    endfunction

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] ins, input logic m);
        exp_t e;
        e = '{pc: pc, instr: ins, mis: m};
        sb_q.push_back(e);
    endtask

    // Scoreboard: every freshly loaded valid IF/ID entry must match the next expected one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_hold = 1'b0;
            end else begin
                if (sb_en && ifc.valid_id && !prev_hold) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_extra: unexpected delivery pc %h instr %h at %0t",
                                 ifc.pc_id, ifc.instr_id, $time);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_pc", ifc.pc_id, e.pc);
                        chk("sb_instr", ifc.instr_id, e.instr);
                        chk("sb_mis", {31'd0, ifc.misalign_id}, {31'd0, e.mis});
                    end
                end
                prev_hold = ifc.stall && !ifc.redirect;
            end
        end
    end

    initial begin
        logic [31:0] wpc;

        //            stall redir rpc         vld pc          instr  mis req addr
        tbl[0]  = mk(0, 0, 32'h0,   0, 32'h0,   NOP,   0, 1, 32'h000);
        tbl[1]  = mk(0, 0, 32'h0,   0, 32'h0,   NOP,   0, 1, 32'h004);
        tbl[2]  = mk(0, 0, 32'h0,   1, 32'h000, 32'h0, 0, 1, 32'h008);
        tbl[3]  = mk(0, 0, 32'h0,   1, 32'h004, 32'h1, 0, 1, 32'h00C);
        tbl[4]  = mk(1, 0, 32'h0,   1, 32'h008, 32'h2, 0, 0, 32'h010);
        tbl[5]  = mk(1, 0, 32'h0,   1, 32'h008, 32'h2, 0, 0, 32'h010);
        tbl[6]  = mk(1, 0, 32'h0,   1, 32'h008, 32'h2, 0, 0, 32'h010);
        tbl[7]  = mk(0, 0, 32'h0,   1, 32'h008, 32'h2, 0, 1, 32'h010);
        tbl[8]  = mk(0, 0, 32'h0,   1, 32'h00C, 32'h3, 0, 1, 32'h014);
        tbl[9]  = mk(0, 0, 32'h0,   1, 32'h010, 32'h4, 0, 1, 32'h018);
        tbl[10] = mk(1, 1, 32'h100, 1, 32'h014, 32'h5, 0, 1, 32'h100);
        tbl[11] = mk(0, 0, 32'h0,   0, 32'h0,   NOP,   0, 1, 32'h104);
        tbl[12] = mk(0, 0, 32'h0,   1, 32'h100, 32'h40, 0, 1, 32'h108);
        tbl[13] = mk(0, 1, 32'h102, 1, 32'h104, 32'h41, 0, 1, 32'h100);
        tbl[14] = mk(0, 0, 32'h0,   0, 32'h0,   NOP,   0, 1, 32'h104);
        tbl[15] = mk(0, 0, 32'h0,   1, 32'h102, 32'h40, 1, 1, 32'h108);
        tbl[16] = mk(0, 0, 32'h0,   1, 32'h104, 32'h41, 0, 1, 32'h10C);
        tbl[17] = mk(0, 0, 32'h0,   1, 32'h108, 32'h42, 0, 1, 32'h110);

        ifc.stall = 1'b0;  ifc.redirect = 1'b0;  ifc.redirect_pc = '0;
        ifc2.stall = 1'b0; ifc2.redirect = 1'b0; ifc2.redirect_pc = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", ifc.pc_id, 32'h0);
        chk("rst_instr", ifc.instr_id, NOP);
        chk("rst_valid", {31'd0, ifc.valid_id}, 32'd0);
        chk("rst_mis", {31'd0, ifc.misalign_id}, 32'd0);
        chk("rst_req", {31'd0, ifc.imem_req}, 32'd0);

        push_exp(32'h000, 32'h0, 0);  push_exp(32'h004, 32'h1, 0);
        push_exp(32'h008, 32'h2, 0);  push_exp(32'h00C, 32'h3, 0);
        push_exp(32'h010, 32'h4, 0);  push_exp(32'h014, 32'h5, 0);
        push_exp(32'h100, 32'h40, 0); push_exp(32'h104, 32'h41, 0);
        push_exp(32'h102, 32'h40, 1); push_exp(32'h104, 32'h41, 0);
        push_exp(32'h108, 32'h42, 0);

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb_en   = 1'b1;

        for (int i = 0; i < 18; i++) begin
            ifc.stall       = tbl[i].stall;
            ifc.redirect    = tbl[i].redirect;
            ifc.redirect_pc = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("c%0d_valid", i), {31'd0, ifc.valid_id}, {31'd0, tbl[i].e_vld});
            chk($sformatf("c%0d_instr", i), ifc.instr_id, tbl[i].e_instr);
            chk($sformatf("c%0d_mis", i), {31'd0, ifc.misalign_id}, {31'd0, tbl[i].e_mis});
            chk($sformatf("c%0d_req", i), {31'd0, ifc.imem_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("c%0d_addr", i), ifc.imem_addr, tbl[i].e_addr);
            if (tbl[i].e_vld)
                chk($sformatf("c%0d_pc", i), ifc.pc_id, tbl[i].e_pc);
            // Wrap-around instance delivers FFFF_FFF8, FFFF_FFFC, 0000_0000 on cycles 2..4.
            if (i >= 2 && i <= 4) begin
                wpc = 32'hFFFF_FFF8 + 32'(4 * (i - 2));
                chk($sformatf("wrap%0d_valid", i), {31'd0, ifc2.valid_id}, 32'd1);
                chk($sformatf("wrap%0d_pc", i), ifc2.pc_id, wpc);
                chk($sformatf("wrap%0d_instr", i), ifc2.instr_id, wpc >> 2);
            end
            @(posedge clk);
            #1;
        end
        chk("sb_drain1", 32'(sb_q.size()), 32'd0);

        // Fill the skid under stall, then reset mid-cycle.
        sb_en = 1'b0;
        ifc.stall = 1'b0; ifc.redirect = 1'b0; ifc.redirect_pc = '0;
        @(posedge clk); #1;
        ifc.stall = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_pc", ifc.pc_id, 32'h0);
        chk("mrst_instr", ifc.instr_id, NOP);
        chk("mrst_valid", {31'd0, ifc.valid_id}, 32'd0);
        chk("mrst_mis", {31'd0, ifc.misalign_id}, 32'd0);
        chk("mrst_req", {31'd0, ifc.imem_req}, 32'd0);

        @(posedge clk); #1;
        push_exp(32'h000, 32'h0, 0); push_exp(32'h004, 32'h1, 0);
        push_exp(32'h008, 32'h2, 0); push_exp(32'h00C, 32'h3, 0);
        ifc.stall = 1'b0;
        reset_n   = 1'b1;
        sb_en     = 1'b1;
        @(negedge clk);
        chk("restart_req", {31'd0, ifc.imem_req}, 32'd1);
        chk("restart_addr", ifc.imem_addr, 32'h0);
        repeat (5) @(negedge clk);
        #1;
        sb_en = 1'b0;
        chk("sb_drain2", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
